// File: rtl/vga_pkg.sv
// Shared VGA raster constants (640x480@60) and small helpers for the timing
// generator and any draw blocks that need to agree on the raster geometry.
package vga_pkg;

  // Raster positions are 10 bits wide; totals above 1024 cannot be represented.
  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] pos_t;
  typedef logic [CNT_W:0]   pos_ext_t;

  localparam int VGA_H_RES  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;

  localparam int VGA_V_RES  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int VGA_H_TOTAL = axis_total(VGA_H_RES, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL = axis_total(VGA_V_RES, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel strobe in, position and sync/enable flags out.
interface vga_timing_if;
  import vga_pkg::*;

  logic pix_en;
  pos_t sx;
  pos_t sy;
  logic de;
  logic hsync;
  logic vsync;
  logic line;
  logic frame;

  modport master (
    input  pix_en,
    output sx, sy, de, hsync, vsync, line, frame
  );

  modport slave (
    input pix_en, sx, sy, de, hsync, vsync, line, frame
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with a registered sync flag and
// a look-ahead active flag describing the position about to be loaded.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_H_RES,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  parameter bit POL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output pos_t count,
  output logic wrap,
  output logic active,
  output logic sync
);

  localparam int       TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam pos_t     LAST       = pos_t'(TOTAL - 1);
  localparam pos_ext_t ACT_END    = pos_ext_t'(ACTIVE);
  localparam pos_ext_t SYNC_START = pos_ext_t'(ACTIVE + FP);
  localparam pos_ext_t SYNC_END   = pos_ext_t'(ACTIVE + FP + SYNC);

  pos_t     count_next;
  pos_ext_t count_ext;
  logic     sync_next;

  // Next-position decode; flags are derived from the value the counter will hold
  // so the registered outputs line up with the registered position.
  always_comb begin
    wrap       = inc && (count == LAST);
    count_next = count;
    if (inc) begin
      count_next = wrap ? '0 : count + pos_t'(1);
    end
    count_ext = pos_ext_t'(count_next);
    active    = count_ext < ACT_END;
    sync_next = (count_ext >= SYNC_START) && (count_ext < SYNC_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= LAST;
      sync  <= ~POL;
    end else if (inc) begin
      count <= count_next;
      sync  <= sync_next ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: horizontal and vertical axis counters plus
// registered data-enable and line/frame start pulses.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_RES  = VGA_H_RES,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_RES  = VGA_V_RES,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input logic          clk,
  input logic          rst,
  vga_timing_if.master bus
);

  logic h_wrap;
  logic h_act;
  logic v_inc;
  logic v_wrap;
  logic v_act;

  logic de_p1;
  logic line_p1;
  logic frame_p1;

  vga_axis_counter #(
    .ACTIVE (H_RES),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL)
  ) h_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (bus.pix_en),
    .count  (bus.sx),
    .wrap   (h_wrap),
    .active (h_act),
    .sync   (bus.hsync)
  );

  // The vertical axis steps once per completed line.
  assign v_inc = bus.pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (V_RES),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL)
  ) v_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (v_inc),
    .count  (bus.sy),
    .wrap   (v_wrap),
    .active (v_act),
    .sync   (bus.vsync)
  );

  // Stage 1: flags registered alongside the position they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_p1    <= 1'b0;
      line_p1  <= 1'b0;
      frame_p1 <= 1'b0;
    end else begin
      de_p1    <= h_act & v_act;
      line_p1  <= h_wrap;
      frame_p1 <= v_wrap;
    end
  end

  assign bus.de    = de_p1;
  assign bus.line  = line_p1;
  assign bus.frame = frame_p1;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default, inverted-polarity and reduced-raster builds.
module tb_vga_timing;

  logic clk;
  logic rst;
  logic pix_en;

  int total_n;
  int fail_n;

  vga_timing_if bd ();
  vga_timing_if bp ();
  vga_timing_if bs ();

  assign bd.pix_en = pix_en;
  assign bp.pix_en = pix_en;
  assign bs.pix_en = pix_en;

  vga_timing dut_def (.clk(clk), .rst(rst), .bus(bd));

  vga_timing #(.H_POL(1'b1), .V_POL(1'b1)) dut_pol (.clk(clk), .rst(rst), .bus(bp));

  // 16 x 8 raster: hsync sx 10..12, vsync sy 5..6, 128 pixels per frame
  vga_timing #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_sm (.clk(clk), .rst(rst), .bus(bs));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic en);
    @(negedge clk);
    rst    = r;
    pix_en = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int de_n, hs_n, hsp_n, vs_n, ln_n, fr_n, pol_bad, sy_bad, hs_first, hs_last;
    int consec, hold_bad, pulse_bad;
    int fr_idx[$];
    logic prev_line;
    logic [9:0] psx, psy;
    logic pde, phs, pvs;
    logic en;

    total_n = 0;
    fail_n  = 0;
    rst     = 1'b1;
    pix_en  = 1'b0;

    // Reset held three cycles with pix_en high
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    check("rst_def_sx", bd.sx, 799);
    check("rst_def_sy", bd.sy, 524);
    check("rst_def_de", bd.de, 0);
    check("rst_def_hsync", bd.hsync, 1);
    check("rst_def_vsync", bd.vsync, 1);
    check("rst_def_line", bd.line, 0);
    check("rst_def_frame", bd.frame, 0);
    check("rst_pol_hsync", bp.hsync, 0);
    check("rst_pol_vsync", bp.vsync, 0);
    check("rst_sm_sx", bs.sx, 15);
    check("rst_sm_sy", bs.sy, 7);

    // One full default line
    de_n = 0; hs_n = 0; hsp_n = 0; vs_n = 0; ln_n = 0; fr_n = 0;
    pol_bad = 0; sy_bad = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 800; i++) begin
      tick(1'b0, 1'b1);
      if (i == 0) begin
        check("first_sx", bd.sx, 0);
        check("first_sy", bd.sy, 0);
        check("first_de", bd.de, 1);
        check("first_line", bd.line, 1);
        check("first_frame", bd.frame, 1);
        check("first_sm_frame", bs.frame, 1);
      end
      if (i == 1) begin
        check("second_sx", bd.sx, 1);
        check("second_line", bd.line, 0);
        check("second_frame", bd.frame, 0);
      end
      de_n  += int'(bd.de);
      hs_n  += int'(bd.hsync == 1'b0);
      hsp_n += int'(bp.hsync);
      vs_n  += int'(bd.vsync);
      ln_n  += int'(bd.line);
      fr_n  += int'(bd.frame);
      if (bd.sy != 10'd0) sy_bad++;
      if (bd.hsync == 1'b0) begin
        if (hs_first < 0) hs_first = int'(bd.sx);
        hs_last = int'(bd.sx);
      end
      if (bp.hsync !== ~bd.hsync || bp.vsync !== ~bd.vsync || bp.sx !== bd.sx ||
          bp.sy !== bd.sy || bp.de !== bd.de) pol_bad++;
    end
    check("line_de_count", de_n, 640);
    check("line_hsync_low_count", hs_n, 96);
    check("line_hsync_first_sx", hs_first, 656);
    check("line_hsync_last_sx", hs_last, 751);
    check("line_vsync_idle", vs_n, 800);
    check("line_line_pulses", ln_n, 1);
    check("line_frame_pulses", fr_n, 1);
    check("line_sy_stable", sy_bad, 0);
    check("pol_hsync_high_count", hsp_n, 96);
    check("pol_vs_default_diff", pol_bad, 0);

    tick(1'b0, 1'b1);
    check("wrap_sx", bd.sx, 0);
    check("wrap_sy", bd.sy, 1);
    check("wrap_line", bd.line, 1);
    check("wrap_frame", bd.frame, 0);
    check("wrap_de", bd.de, 1);

    // Full reduced frame with pix_en constantly high
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    de_n = 0; hs_n = 0; vs_n = 0; ln_n = 0; consec = 0; prev_line = 1'b0;
    fr_idx.delete();
    for (int i = 0; i < 257; i++) begin
      tick(1'b0, 1'b1);
      if (bs.frame) fr_idx.push_back(i);
      if (i < 128) begin
        de_n += int'(bs.de);
        hs_n += int'(bs.hsync == 1'b0);
        vs_n += int'(bs.vsync == 1'b0);
        ln_n += int'(bs.line);
        if (bs.line && prev_line) consec++;
      end
      prev_line = bs.line;
    end
    check("sm_frame_pulses", fr_idx.size(), 3);
    check("sm_frame_first", (fr_idx.size() >= 1) ? fr_idx[0] : -1, 0);
    check("sm_frame_period", (fr_idx.size() >= 2) ? fr_idx[1] - fr_idx[0] : -1, 128);
    check("sm_de_count", de_n, 32);
    check("sm_hsync_low_count", hs_n, 24);
    check("sm_vsync_low_count", vs_n, 32);
    check("sm_line_pulses", ln_n, 8);
    check("sm_line_width", consec, 0);

    // pix_en alternating 1/0
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    ln_n = 0; hold_bad = 0; pulse_bad = 0; consec = 0; prev_line = 1'b0;
    fr_idx.delete();
    psx = '0; psy = '0; pde = 1'b0; phs = 1'b0; pvs = 1'b0;
    for (int i = 0; i < 258; i++) begin
      en = ((i % 2) == 0);
      tick(1'b0, en);
      if (!en) begin
        if (bs.sx !== psx || bs.sy !== psy || bs.de !== pde ||
            bs.hsync !== phs || bs.vsync !== pvs) hold_bad++;
        if (bs.line || bs.frame) pulse_bad++;
      end
      if (bs.frame) fr_idx.push_back(i);
      if (i < 256) ln_n += int'(bs.line);
      if (bs.line && prev_line) consec++;
      prev_line = bs.line;
      psx = bs.sx; psy = bs.sy; pde = bs.de; phs = bs.hsync; pvs = bs.vsync;
    end
    check("tog_hold", hold_bad, 0);
    check("tog_pulse_on_idle", pulse_bad, 0);
    check("tog_frame_pulses", fr_idx.size(), 2);
    check("tog_frame_period", (fr_idx.size() >= 2) ? fr_idx[1] - fr_idx[0] : -1, 256);
    check("tog_line_pulses", ln_n, 8);
    check("tog_line_width", consec, 0);

    // Reset asserted mid-frame (pix_en low on the reset edge)
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 44; i++) tick(1'b0, 1'b1);
    check("mid_sm_sx", bs.sx, 11);
    check("mid_sm_sy", bs.sy, 2);
    check("mid_sm_hsync", bs.hsync, 0);
    check("mid_sm_de", bs.de, 0);
    check("mid_def_sx", bd.sx, 43);
    tick(1'b1, 1'b0);
    check("mrst_sm_sx", bs.sx, 15);
    check("mrst_sm_sy", bs.sy, 7);
    check("mrst_sm_de", bs.de, 0);
    check("mrst_sm_hsync", bs.hsync, 1);
    check("mrst_sm_vsync", bs.vsync, 1);
    check("mrst_sm_line", bs.line, 0);
    check("mrst_sm_frame", bs.frame, 0);
    check("mrst_def_sx", bd.sx, 799);
    check("mrst_def_sy", bd.sy, 524);
    check("mrst_pol_hsync", bp.hsync, 0);
    tick(1'b0, 1'b1);
    check("restart_sm_sx", bs.sx, 0);
    check("restart_sm_sy", bs.sy, 0);
    check("restart_sm_de", bs.de, 1);
    check("restart_sm_frame", bs.frame, 1);
    check("restart_def_frame", bd.frame, 1);
    tick(1'b0, 1'b1);
    check("restart_sm_sx1", bs.sx, 1);
    check("restart_sm_frame1", bs.frame, 0);

    $display("%0d/%0d checks passed", total_n - fail_n, total_n);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_RES, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_RES, default 480, visible lines per frame.
REQ-006 Parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porches and sync width in lines.
REQ-007 Parameters H_POL and V_POL, default 0 each; 0 means the sync output is active-low, 1 means active-high.
REQ-008 clk  input  1  pixel-domain clock; one clock, all logic on its rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 pix_en  input  1  pixel strobe; the raster advances one pixel on each clk edge where pix_en=1.
REQ-011 sx  output  10  current horizontal position, 0..H_TOTAL-1.
REQ-012 sy  output  10  current vertical position, 0..V_TOTAL-1.
REQ-013 de  output  1  data enable; high only when sx<H_RES and sy<V_RES.
REQ-014 hsync  output  1  horizontal sync at polarity H_POL.
REQ-015 vsync  output  1  vertical sync at polarity V_POL.
REQ-016 line  output  1  single-clk pulse when the raster enters sx=0.
REQ-017 frame  output  1  single-clk pulse when the raster enters sx=0, sy=0.

Function
REQ-018 H_TOTAL SHALL be H_RES+H_FP+H_SYNC+H_BP (800 at defaults), and V_TOTAL SHALL be V_RES+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-019 On a clk edge with pix_en=1, sx SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0 and sy SHALL increment by 1.
REQ-020 sy SHALL wrap from V_TOTAL-1 to 0 on the same edge that sx wraps to 0.
REQ-021 On a clk edge with pix_en=0, sx, sy, de, hsync and vsync SHALL all hold their values.
REQ-022 de, hsync and vsync SHALL be registered and SHALL be cycle-aligned with sx/sy, with zero offset between position and flags.
REQ-023 hsync SHALL be asserted exactly when H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC (sx 656..751 at defaults).
REQ-024 vsync SHALL be asserted exactly when V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC (sy 490..491 at defaults), for all sx on those lines.
REQ-025 line SHALL be high for exactly one clk cycle, on the cycle following an advancing edge that produced sx=0, and low otherwise, even if pix_en stays low.
REQ-026 frame SHALL follow the same rule as line, but only for the edge that produced sx=0, sy=0; frame high therefore implies line high.
REQ-027 All outputs SHALL be driven directly from flops, with no combinational path from pix_en to any output.
REQ-028 Counter widths SHALL be 10 bits; parameter sets with H_TOTAL>1024 or V_TOTAL>1024 are unsupported.

Reset
REQ-029 While rst=1 at a clk edge, the block SHALL load sx=H_TOTAL-1, sy=V_TOTAL-1, de=0, hsync/vsync inactive, and line=0, frame=0, regardless of pix_en.
REQ-030 rst SHALL take priority over pix_en; a reset asserted mid-frame SHALL take effect on that same edge.
REQ-031 The first pix_en=1 edge after reset release SHALL produce sx=0, sy=0, de=1, line=1, frame=1.

Structure
REQ-032 The 640x480@60 timing constants and the H_TOTAL/V_TOTAL derivations SHALL live in shared package vga_pkg, for reuse by draw blocks.
REQ-033 A single sub-module, vga_axis_counter, SHALL be instantiated twice (horizontal, vertical); it is parameterized by active/fp/sync/bp, takes inc, and produces count, wrap, active and sync.
REQ-034 The vertical instance's inc SHALL be the horizontal instance's (pix_en and wrap).

Verification
REQ-035 Scenario: rst high for 3 clk, then pix_en=1 constantly -> first edge gives sx=0, sy=0, de=1, frame=1, line=1; next edge gives sx=1, frame=0, line=0.
REQ-036 Scenario: pix_en=1 for a full line -> de is high for exactly 640 clk, hsync is low for exactly 96 clk starting at sx=656, and sx wraps 799->0 with sy incrementing.
REQ-037 Scenario: run a full frame -> exactly 420000 clk cycles (800x525) between frame pulses, 525 line pulses per frame, vsync low for exactly 1600 clk, and de high for 307200 clk.
REQ-038 Scenario: pix_en toggling 1/0 each clk -> outputs change only on enabled edges, the frame period is 840000 clk, and line/frame pulses are 1 clk wide.
REQ-039 Scenario: rst asserted at sx=700, sy=300 -> next edge shows sx=799, sy=524, de=0, hsync=1, vsync=1; the raster restarts cleanly afterwards.
REQ-040 Scenario: H_POL=1, V_POL=1 build -> sync outputs are inverted versus the defaults, with identical positions and widths.
